mux64_rr_arbiter: RTL and testbench
===================================

// Module: mux64_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one mux64x1 output channel among 64 requesters.
//   Picks one requester, drives the mux select and a one-hot grant, and holds the grant until release.
//   Release occurs on done, on the grantee dropping req, or on a hold-limit timeout.
//   Sits directly upstream of mux64x1: sel -> mux sel, req/gnt -> requester side.
// PARAMETERS
//   N_REQ     64   number of requesters; fixed to the mux width
//   SEL_W     6    select width, = clog2(N_REQ)
//   MAX_HOLD  16   max cycles a grant may be held before forced release (>=1)
//   HOLD_W    5    hold counter width, = clog2(MAX_HOLD+1)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   en         in   1      1 = new grants allowed; 0 = finish current grant, issue no new grant
//   req        in   64     request vector, level-sensitive, bit i = requester i
//   done       in   1      grantee signals end of use; sampled only in GRANT
//   sel        out  SEL_W  index driven to mux64x1 sel; registered
//   gnt        out  64     one-hot grant, = (1<<sel) when gnt_valid, else 0; registered
//   gnt_valid  out  1      a grant is active
//   timeout    out  1      one-cycle pulse when a grant is forcibly released at MAX_HOLD
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, sel=0, gnt=0, gnt_valid=0, timeout=0, hold_cnt=0,
//     ptr=N_REQ-1, so the first search starts at index 0. Reset mid-grant aborts the grant immediately.
//   States: IDLE, GRANT, GAP.
//   IDLE: if en && |req, pick = first set bit searching ptr+1, ptr+2, ..., wrapping at 63->0,
//     ending at ptr (ptr itself is lowest priority). Next cycle: GRANT, sel=pick,
//     gnt=1<<pick, gnt_valid=1, ptr=pick, hold_cnt=1. Latency from req to grant is 1 cycle.
//     Otherwise stay in IDLE and leave all outputs unchanged (gnt=0).
//   GRANT: sel, gnt are stable for the whole grant. Release condition, in priority order:
//     (a) done=1, or (b) req[sel]=0, or (c) hold_cnt==MAX_HOLD. On (c) only, timeout=1 for that cycle.
//     When done and the limit coincide, release is normal and timeout stays 0.
//     On release the next state is GAP, with gnt=0 and gnt_valid=0.
//     If no release, hold_cnt increments (saturating at MAX_HOLD).
//   GAP: one dead cycle (break-before-make); sel holds its last value; next state is IDLE.
//     Minimum spacing between grants is therefore 1 GRANT cycle + GAP + IDLE.
//   en=0 does not affect an active grant; it only blocks the IDLE->GRANT transition.
//   Fairness: a continuously requesting requester is granted within N_REQ-1 intervening grants.
//   ptr updates only on grant, not on timeout or release.
//   A pick never selects a req bit that is 0. All outputs come from flops, with no comb paths in->out.
// STRUCTURE
//   Package mux_arb_pkg contains:
//     - N_REQ and SEL_W localparams;
//     - typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
//     - typedef logic [SEL_W-1:0] sel_t.
//   Sub-module rr_priority_pick: combinational, inputs req[63:0] and ptr; outputs found and idx[5:0].
//     Implement it as rotate-by-(ptr+1), find-first-set, then add back mod 64.
//   The top level holds the FSM, ptr, hold_cnt and output registers, and instantiates mux64x1 in the bench only.
// TESTING
//   1 Reset: hold rst 2 cycles with req=all-ones -> sel=0, gnt=0, gnt_valid=0; 1 cycle after rst falls, gnt=1<<0.
//   2 Rotation: req=bits{3,10,63}, done pulsed 1 cycle after each grant -> grant order 3,10,63,3;
//       the 63->3 step checks wrap; GAP cycle has gnt=0.
//   3 Timeout: req[5]=1 held, done=0, MAX_HOLD=16 -> timeout pulse on the 16th GRANT cycle,
//       then gnt=0 for 2 cycles, then regrant to 5 only if no other req is set.
//   4 Coincidence: done=1 exactly at hold_cnt==MAX_HOLD -> release with timeout=0;
//       also drop req[sel] mid-grant -> release next edge, no timeout.
//   5 Enable: en=0 with req[7]=1 -> no grant for 20 cycles; en->0 during an active grant
//       -> the grant continues until done, then no new grant.
//   6 Mid-op reset plus end-to-end: assert rst during GRANT -> outputs zero next edge, ptr=63.
//       Random req/done for 10k cycles, with bench mux64x1 in=random and a scoreboard checking
//       out==in[sel] whenever gnt_valid, gnt one-hot or zero, and fairness <=63 grants.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 64-way round-robin mux arbiter.
// Imported by the priority picker and the arbiter top level.
package mux_arb_pkg;

    localparam int N_REQ = 64;
    localparam int SEL_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_REQ-1:0] req_t;

    function automatic req_t onehot(input sel_t s);
        onehot = req_t'(1) << s;
    endfunction

endpackage

// File: rtl/mux64_rr_arbiter_pick.sv
// Round-robin priority pick: first set request after ptr, wrapping.
// Rotate so ptr+1 lands at bit 0, find-first-set, then add the offset back.
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             found,
    output sel_t             idx
);

    sel_t start;
    sel_t off;
    req_t rot;

    assign start = ptr + sel_t'(1);
    assign rot   = (req >> start) | (req << (N_REQ - int'(start)));

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = sel_t'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = off + start;

endmodule

// File: rtl/mux64_rr_arbiter.sv
// Round-robin arbiter owning the select of a 64:1 output mux.
// Grants are held until done, request drop or hold-limit, then one dead cycle.
module mux64_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output sel_t             sel,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t        state;
    sel_t              ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              found;
    sel_t              pick;
    logic              at_limit;
    logic              released;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    assign at_limit = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign released = done || !req[sel] || at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= sel_t'(N_REQ - 1);
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && found) begin
                        state     <= GRANT;
                        sel       <= pick;
                        gnt       <= onehot(pick);
                        gnt_valid <= 1'b1;
                        ptr       <= pick;
                        hold_cnt  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (released) begin
                        state     <= GAP;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        // forced release only when neither normal cause applies
                        timeout   <= !done && req[sel];
                    end else if (!at_limit) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// Bench for mux64_rr_arbiter: directed table, hand sequences and
// a randomized run against an abstract ownership model.
module tb_mux64_rr_arbiter;

    localparam int MAX_HOLD = 16;
    localparam logic [63:0] ALL = '1;
    localparam logic [63:0] R3  = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [63:0] req = '0;
    logic        done = 1'b0;
    logic [5:0]  sel;
    logic [63:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    logic [7:0] mux_in [64];
    logic [7:0] mux_out;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    int   m_owner = -1;
    int   m_held = 0;
    int   m_dead = 0;
    int   m_last = 63;
    int   m_sel = 0;
    logic m_gv = 1'b0;
    logic m_to = 1'b0;
    int   m_wait [64];

    always #5 clk = ~clk;

    mux64_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    assign mux_out = mux_in[sel];

    typedef struct {
        logic        rst;
        logic        en;
        logic [63:0] req;
        logic        done;
        logic        gv;
        logic [5:0]  sel;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        int pick;
        int mx;
        m_to = 1'b0;
        pick = -1;
        if (rst) begin
            m_owner = -1;
            m_held = 0;
            m_dead = 0;
            m_last = 63;
            m_sel = 0;
            m_gv = 1'b0;
            for (int i = 0; i < 64; i++) m_wait[i] = 0;
        end else begin
            if (m_gv) begin
                if (done || !req[m_owner] || m_held == MAX_HOLD) begin
                    m_to = !done && req[m_owner];
                    m_gv = 1'b0;
                    m_owner = -1;
                    m_dead = 1;
                end else begin
                    m_held++;
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else if (en && req != 0) begin
                for (int k = 1; k <= 64; k++) begin
                    if (pick < 0 && req[(m_last + k) % 64]) pick = (m_last + k) % 64;
                end
                m_owner = pick;
                m_sel = pick;
                m_gv = 1'b1;
                m_held = 1;
                m_last = pick;
            end
            mx = 0;
            for (int i = 0; i < 64; i++) begin
                if (!req[i] || i == pick) m_wait[i] = 0;
                else if (pick >= 0) m_wait[i]++;
                if (m_wait[i] > mx) mx = m_wait[i];
            end
            if (pick >= 0) chk("fairness_over_63", 64'(mx > 63), 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_gnt_valid", 64'(gnt_valid), 64'(m_gv));
        chk("model_sel", 64'(sel), 64'(m_sel));
        chk("model_gnt", gnt, m_gv ? (64'd1 << m_sel) : 64'd0);
        chk("model_timeout", 64'(timeout), 64'(m_to));
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        if (gnt_valid) chk("mux_out", 64'(mux_out), 64'(mux_in[m_sel]));
    endtask

    task automatic expect_out(input string name, input logic gv, input logic [5:0] s, input logic to);
        chk({name, "_gv"}, 64'(gnt_valid), 64'(gv));
        chk({name, "_to"}, 64'(timeout), 64'(to));
        if (gv) begin
            chk({name, "_sel"}, 64'(sel), 64'(s));
            chk({name, "_gnt"}, gnt, 64'd1 << s);
        end else begin
            chk({name, "_gnt"}, gnt, 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mux_in[i] = 8'(i);
            m_wait[i] = 0;
        end

        // rst en req done | gv sel to
        tbl.push_back('{1'b1, 1'b1, ALL, 1'b0, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, ALL, 1'b0, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, ALL, 1'b0, 1'b1, 6'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, ALL, 1'b1, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b1, 6'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b1, 1'b0, 6'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b0, 6'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b1, 6'd10, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b1, 1'b0, 6'd10, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b0, 6'd10, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b1, 6'd63, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b1, 1'b0, 6'd63, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b0, 6'd63, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b0, 1'b1, 6'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, R3, 1'b1, 1'b0, 6'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b0, 6'd3, 1'b0});

        for (int r = 0; r < tbl.size(); r++) begin
            rst = tbl[r].rst;
            en = tbl[r].en;
            req = tbl[r].req;
            done = tbl[r].done;
            step();
            chk($sformatf("tbl%0d_gv", r), 64'(gnt_valid), 64'(tbl[r].gv));
            chk($sformatf("tbl%0d_sel", r), 64'(sel), 64'(tbl[r].sel));
            chk($sformatf("tbl%0d_to", r), 64'(timeout), 64'(tbl[r].to));
            chk($sformatf("tbl%0d_gnt", r), gnt,
                tbl[r].gv ? (64'd1 << tbl[r].sel) : 64'd0);
        end

        // hold-limit timeout on a lone requester
        req = 64'd1 << 5;
        step();
        expect_out("to_first", 1'b1, 6'd5, 1'b0);
        for (int k = 2; k <= MAX_HOLD; k++) begin
            step();
            expect_out("to_hold", 1'b1, 6'd5, 1'b0);
        end
        step();
        expect_out("to_pulse", 1'b0, 6'd5, 1'b1);
        step();
        expect_out("to_idle", 1'b0, 6'd5, 1'b0);
        step();
        expect_out("to_regrant", 1'b1, 6'd5, 1'b0);

        // done coinciding with the limit is a normal release
        for (int k = 2; k <= MAX_HOLD; k++) step();
        done = 1'b1;
        step();
        expect_out("coinc", 1'b0, 6'd5, 1'b0);
        done = 1'b0;
        step();
        step();
        expect_out("drop_grant", 1'b1, 6'd5, 1'b0);
        step();
        step();
        req = '0;
        step();
        expect_out("drop_rel", 1'b0, 6'd5, 1'b0);

        // enable gating
        en = 1'b0;
        req = 64'd1 << 7;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("en0_nogrant", 64'(gnt_valid), 64'd0);
        end
        en = 1'b1;
        step();
        expect_out("en1_grant", 1'b1, 6'd7, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("en0_keep", 1'b1, 6'd7, 1'b0);
        end
        done = 1'b1;
        step();
        expect_out("en0_rel", 1'b0, 6'd7, 1'b0);
        done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en0_after", 64'(gnt_valid), 64'd0);
        end

        // reset in the middle of a grant restores the search pointer
        en = 1'b1;
        step();
        expect_out("mid_grant", 1'b1, 6'd7, 1'b0);
        rst = 1'b1;
        step();
        expect_out("mid_rst", 1'b0, 6'd0, 1'b0);
        chk("mid_rst_sel", 64'(sel), 64'd0);
        rst = 1'b0;
        req = (64'd1 << 7) | (64'd1 << 63);
        step();
        expect_out("ptr_reset", 1'b1, 6'd7, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;

        // randomized run
        req = {$urandom, $urandom};
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 64; i++) mux_in[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 63)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0) req = {$urandom, $urandom};
            done = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 19) != 0);
            rst = ($urandom_range(0, 1999) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
